// File: rtl/frame_tx_arbiter_if.sv
// frame_tx_arbiter_if: source and merged AXI-Stream bundles of the frame arbiter
interface frame_tx_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_tdata;
    logic [NUM_SRC*8-1:0]          S_AXIS_tkeep;
    logic [NUM_SRC-1:0]            S_AXIS_tvalid;
    logic [NUM_SRC-1:0]            S_AXIS_tlast;
    logic [NUM_SRC-1:0]            S_AXIS_tready;
    logic [DATA_WIDTH-1:0]         M_AXIS_tdata;
    logic [7:0]                    M_AXIS_tkeep;
    logic                          M_AXIS_tvalid;
    logic                          M_AXIS_tlast;
    logic                          M_AXIS_tready;

    modport master (
        output S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tvalid, S_AXIS_tlast, M_AXIS_tready,
        input  S_AXIS_tready, M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tvalid, M_AXIS_tlast
    );

    modport slave (
        input  S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tvalid, S_AXIS_tlast, M_AXIS_tready,
        output S_AXIS_tready, M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tvalid, M_AXIS_tlast
    );
endinterface

// File: rtl/frame_tx_arbiter.sv
// frame_tx_arbiter: frame-granular round-robin merge of NUM_SRC AXI-Stream sources with a programmable inter-frame gap
module frame_tx_arbiter #(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int GAP_WIDTH  = 8,
    localparam int GW         = $clog2(NUM_SRC)
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    frame_tx_arbiter_if.slave    axis,
    input  logic [NUM_SRC-1:0]   Src_Enable,
    input  logic [GAP_WIDTH-1:0] Gap_Cycles,
    output logic [GW-1:0]        Grant_Idx,
    output logic                 Busy,
    output logic [15:0]          Frames_Sent
);
    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]          frames_sent_q, frames_sent_d;
    logic [NUM_SRC-1:0]   req;
    logic [GW-1:0]        pick, idx;
    logic                 found, streaming, last_hs;

    assign req       = axis.S_AXIS_tvalid & Src_Enable;
    assign streaming = (state_q == STREAM);

    assign axis.M_AXIS_tdata  = streaming ? axis.S_AXIS_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign axis.M_AXIS_tkeep  = streaming ? axis.S_AXIS_tkeep[int'(grant_q)*8 +: 8] : '0;
    assign axis.M_AXIS_tvalid = streaming & axis.S_AXIS_tvalid[grant_q];
    assign axis.M_AXIS_tlast  = streaming & axis.S_AXIS_tlast[grant_q];
    assign axis.S_AXIS_tready = streaming ? (NUM_SRC'(axis.M_AXIS_tready) << grant_q) : '0;

    assign last_hs     = axis.M_AXIS_tvalid & axis.M_AXIS_tready & axis.M_AXIS_tlast;
    assign Grant_Idx   = grant_q;
    assign Busy        = (state_q != IDLE);
    assign Frames_Sent = frames_sent_q;

    // Round-robin search for the first eligible source after the previous winner
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = GW'((int'(last_grant_q) + i) % NUM_SRC);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next state: grant held for the whole frame, gap sampled on the tlast handshake
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        gap_cnt_d     = gap_cnt_q;
        frames_sent_d = frames_sent_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_hs) begin
                    last_grant_d  = grant_q;
                    frames_sent_d = frames_sent_q + 16'd1;
                    gap_cnt_d     = Gap_Cycles;
                    state_d       = (Gap_Cycles == '0) ? IDLE : GAP;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                if (gap_cnt_q <= GAP_WIDTH'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset gives source 0 first priority
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= GW'(NUM_SRC - 1);
            gap_cnt_q     <= '0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            gap_cnt_q     <= gap_cnt_d;
            frames_sent_q <= frames_sent_d;
        end
    end
endmodule

// File: tb/tb_frame_tx_arbiter.sv
// tb_frame_tx_arbiter: directed bench for the frame arbiter with per-source frame generators
module tb_frame_tx_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  Src_Enable;
    logic [7:0]  Gap_Cycles;
    logic [1:0]  Grant_Idx;
    logic        Busy;
    logic [15:0] Frames_Sent;

    int         fr[4], bc[4], len[4];
    logic [3:0] hold;
    logic [7:0] order[$];
    int         checks = 0, errors = 0;
    int         nb, phase, gap_n, idle_n;

    frame_tx_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH(64)) bus ();

    frame_tx_arbiter #(.NUM_SRC(4), .DATA_WIDTH(64), .GAP_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .axis(bus), .Src_Enable(Src_Enable),
        .Gap_Cycles(Gap_Cycles), .Grant_Idx(Grant_Idx), .Busy(Busy), .Frames_Sent(Frames_Sent)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.S_AXIS_tvalid[i]         = (fr[i] > 0) && !hold[i];
            bus.S_AXIS_tlast[i]          = (bc[i] == len[i] - 1);
            bus.S_AXIS_tdata[i*64 +: 64] = {8'(i), 40'h0, 8'(fr[i]), 8'(bc[i])};
            bus.S_AXIS_tkeep[i*8 +: 8]   = 8'(i * 16 + bc[i]);
        end
    endtask

    task automatic cyc();
        logic [3:0] fire;
        #1;
        fire = bus.S_AXIS_tready & bus.S_AXIS_tvalid;
        if (bus.M_AXIS_tvalid && bus.M_AXIS_tready && bus.M_AXIS_tlast) order.push_back(bus.M_AXIS_tdata[63:56]);
        @(posedge ACLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) begin
                if (bc[i] == len[i] - 1) begin
                    bc[i] = 0;
                    fr[i]--;
                end else bc[i]++;
            end
        end
        drive();
        @(negedge ACLK);
    endtask

    task automatic run(input int max);
        int n = 0;
        #1;
        while ((((bus.S_AXIS_tvalid & Src_Enable) != 0) || Busy) && n < max) begin
            cyc();
            #1;
            n++;
        end
        check("run_done", 64'(n < max), 1);
    endtask

    initial begin
        ARESET = 1'b1;
        Src_Enable = 4'hF;
        Gap_Cycles = 8'd0;
        hold = 4'h0;
        bus.M_AXIS_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fr[i] = 0; bc[i] = 0; len[i] = 1;
        end
        drive();
        repeat (2) @(negedge ACLK);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_grant", Grant_Idx, 0);
        check("rst_frames", Frames_Sent, 0);
        check("rst_tready", bus.S_AXIS_tready, 0);
        check("rst_tvalid", bus.M_AXIS_tvalid, 0);
        check("rst_tlast", bus.M_AXIS_tlast, 0);
        @(negedge ACLK);
        ARESET = 1'b0;

        // two contending sources, strict rotation
        order.delete();
        fr[0] = 2; len[0] = 3; fr[2] = 2; len[2] = 3;
        drive();
        cyc();
        #1;
        check("t1_grant", Grant_Idx, 0);
        check("t1_busy", Busy, 1);
        check("t1_tdata", bus.M_AXIS_tdata, {8'd0, 40'h0, 8'd2, 8'd0});
        check("t1_tkeep", bus.M_AXIS_tkeep, 8'h00);
        check("t1_tready", bus.S_AXIS_tready, 4'b0001);
        run(40);
        check("t1_cnt", order.size(), 4);
        check("t1_o0", order[0], 0);
        check("t1_o1", order[1], 2);
        check("t1_o2", order[2], 0);
        check("t1_o3", order[3], 2);
        check("t1_frames", Frames_Sent, 4);

        // backpressure toggling on a single 4-beat frame
        order.delete();
        fr[1] = 1; len[1] = 4;
        drive();
        nb = 0;
        for (int c = 0; c < 16 && nb < 4; c++) begin
            bus.M_AXIS_tready = (c % 2 == 0);
            #1;
            if (bus.M_AXIS_tvalid) begin
                check("t2_tready", bus.S_AXIS_tready, {2'b00, bus.M_AXIS_tready, 1'b0});
                if (bus.M_AXIS_tready) begin
                    check("t2_tdata", bus.M_AXIS_tdata, {8'd1, 40'h0, 8'd1, 8'(nb)});
                    check("t2_tkeep", bus.M_AXIS_tkeep, 8'h10 + nb);
                    nb++;
                end
            end
            cyc();
        end
        bus.M_AXIS_tready = 1'b1;
        #1;
        check("t2_beats", nb, 4);
        check("t2_order", order[0], 1);
        check("t2_busy", Busy, 0);
        check("t2_frames", Frames_Sent, 5);

        // inter-frame gap of 5 cycles
        Gap_Cycles = 8'd5;
        fr[3] = 2; len[3] = 2;
        drive();
        phase = 0; gap_n = 0; idle_n = 0;
        for (int c = 0; c < 40 && phase != 2; c++) begin
            #1;
            if (phase == 1) begin
                if (bus.M_AXIS_tvalid) phase = 2;
                else if (Busy) begin
                    gap_n++;
                    check("t3_gap_rdy", bus.S_AXIS_tready, 0);
                end else idle_n++;
            end else if (bus.M_AXIS_tvalid && bus.M_AXIS_tready && bus.M_AXIS_tlast) phase = 1;
            cyc();
        end
        Gap_Cycles = 8'd0;
        check("t3_reached", phase, 2);
        check("t3_gap", gap_n, 5);
        check("t3_idle", idle_n, 1);
        run(40);
        check("t3_frames", Frames_Sent, 7);

        // source 1 masked while all sources contend
        order.delete();
        Src_Enable = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            fr[i] = 2; len[i] = 2;
        end
        drive();
        run(80);
        check("t4_cnt", order.size(), 6);
        check("t4_o0", order[0], 0);
        check("t4_o1", order[1], 2);
        check("t4_o2", order[2], 3);
        check("t4_o3", order[3], 0);
        check("t4_o4", order[4], 2);
        check("t4_o5", order[5], 3);
        check("t4_frames", Frames_Sent, 13);

        // enable dropped and source stalled mid-frame
        Src_Enable = 4'b0010;
        fr[1] = 1; len[1] = 3;
        drive();
        cyc();
        #1;
        check("t4_grant1", Grant_Idx, 1);
        check("t4_valid", bus.M_AXIS_tvalid, 1);
        Src_Enable = 4'b0000;
        cyc();
        hold[1] = 1'b1;
        drive();
        #1;
        check("t4_stall_v", bus.M_AXIS_tvalid, 0);
        check("t4_stall_g", Grant_Idx, 1);
        check("t4_stall_b", Busy, 1);
        cyc();
        #1;
        check("t4_stall_v2", bus.M_AXIS_tvalid, 0);
        hold[1] = 1'b0;
        drive();
        #1;
        check("t4_resume", bus.M_AXIS_tdata, {8'd1, 40'h0, 8'd1, 8'd1});
        cyc();
        cyc();
        #1;
        check("t4_done", Busy, 0);
        check("t4_frames2", Frames_Sent, 14);

        // asynchronous reset on beat 2 of a 5-beat frame
        Src_Enable = 4'hF;
        fr[0] = 1; len[0] = 5;
        drive();
        cyc();
        cyc();
        #1;
        check("t5_beat2", bus.M_AXIS_tdata[7:0], 1);
        ARESET = 1'b1;
        #1;
        check("t5_tvalid", bus.M_AXIS_tvalid, 0);
        check("t5_tlast", bus.M_AXIS_tlast, 0);
        check("t5_tready", bus.S_AXIS_tready, 0);
        check("t5_busy", Busy, 0);
        check("t5_grant", Grant_Idx, 0);
        check("t5_frames", Frames_Sent, 0);
        order.delete();
        fr[0] = 1; bc[0] = 0; len[0] = 1;
        fr[2] = 1; bc[2] = 0; len[2] = 1;
        drive();
        cyc();
        ARESET = 1'b0;
        cyc();
        #1;
        check("t5_first", Grant_Idx, 0);
        check("t5_busy2", Busy, 1);
        run(20);
        check("t5_o0", order[0], 0);
        check("t5_o1", order[1], 2);
        check("t5_frames2", Frames_Sent, 2);

        // frame counter wrap from a preloaded 65534
        force dut.frames_sent_q = 16'hFFFE;
        cyc();
        release dut.frames_sent_q;
        #1;
        check("t6_preload", Frames_Sent, 16'hFFFE);
        fr[3] = 1; len[3] = 1;
        drive();
        run(20);
        check("t6_max", Frames_Sent, 16'hFFFF);
        fr[3] = 1;
        drive();
        run(20);
        check("t6_wrap", Frames_Sent, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_tx_arbiter.md
FRAME_TX_ARBITER -- requirements
Module: frame_tx_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of upstream AXI-Stream frame sources (2..8).
REQ-002 Parameter DATA_WIDTH, default 64, tdata width per source and on output.
REQ-003 Parameter GAP_WIDTH, default 8, width of the inter-frame gap configuration.
REQ-004 ACLK  in  1  single clock; all logic rising-edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 S_AXIS_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 S_AXIS_tkeep  in  NUM_SRC*8  byte enables per source.
REQ-008 S_AXIS_tvalid / S_AXIS_tlast  in  NUM_SRC each  per-source valid and last.
REQ-009 S_AXIS_tready  out  NUM_SRC  per-source ready.
REQ-010 M_AXIS_tdata / M_AXIS_tkeep / M_AXIS_tvalid / M_AXIS_tlast  out  DATA_WIDTH/8/1/1  merged output stream.
REQ-011 M_AXIS_tready  in  1  downstream ready.
REQ-012 Src_Enable  in  NUM_SRC  per-source arbitration mask; 1 = eligible.
REQ-013 Gap_Cycles  in  GAP_WIDTH  idle cycles forced after each frame.
REQ-014 Grant_Idx  out  $clog2(NUM_SRC)  index of the current or last granted source.
REQ-015 Busy  out  1  high in STREAM or GAP.
REQ-016 Frames_Sent  out  16  count of completed output frames, wraps at 65535->0.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, GAP.
REQ-018 IDLE: when any i has S_AXIS_tvalid[i] & Src_Enable[i], the block SHALL register grant = first such i searching round-robin from last_grant+1 (mod NUM_SRC) and enter STREAM next cycle.
REQ-019 IDLE and GAP: all S_AXIS_tready SHALL be 0, and M_AXIS_tvalid SHALL be 0.
REQ-020 STREAM: M_AXIS_tdata/tkeep/tvalid/tlast SHALL combinationally equal the granted source's signals; S_AXIS_tready[grant] = M_AXIS_tready; all other tready = 0.
REQ-021 Grant SHALL be held for the whole frame; no re-arbitration before the tlast beat handshakes (M_AXIS_tvalid & M_AXIS_tready & M_AXIS_tlast).
REQ-022 On the tlast handshake: last_grant <= grant; Frames_Sent increments by 1; Gap_Cycles is sampled; next state = IDLE if sampled value is 0, else GAP with counter loaded with the sampled value.
REQ-023 GAP SHALL last exactly Gap_Cycles cycles, then return to IDLE; minimum turnaround from tlast handshake to next STREAM entry is therefore Gap_Cycles+1 cycles.
REQ-024 Src_Enable or Gap_Cycles changes during STREAM SHALL NOT abort or affect the current frame; Src_Enable is evaluated only in IDLE.
REQ-025 Source deasserting tvalid mid-frame SHALL stall the output (M_AXIS_tvalid=0) while keeping the grant.
REQ-026 All eligible sources simultaneously valid SHALL be served in strict rotation, one frame each.
REQ-027 Single-beat frame (tvalid & tlast on first beat) SHALL complete in one STREAM cycle when M_AXIS_tready=1.
REQ-028 Grant_Idx SHALL show the registered grant; Busy = (state != IDLE).

Reset
REQ-029 While ARESET=1: state=IDLE, grant=0, last_grant=NUM_SRC-1 (source 0 has first priority), gap counter=0, Frames_Sent=0, all S_AXIS_tready=0, M_AXIS_tvalid=0, M_AXIS_tlast=0, Busy=0, Grant_Idx=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame immediately; no partial-frame recovery; after release the first arbitration follows REQ-018.

Verification
REQ-031 Sources 0 and 2 valid, Src_Enable=4'hF, Gap_Cycles=0, 3-beat frames -> output frame order 0,2,0,2; Frames_Sent=4; Busy=1 during transfers.
REQ-032 Source 1 sends a 4-beat frame, M_AXIS_tready toggles 1,0,1,0 -> all 4 beats emitted unchanged, S_AXIS_tready[1] mirrors M_AXIS_tready, other tready stay 0.
REQ-033 Gap_Cycles=5, source 3 sends two back-to-back frames -> exactly 5 GAP cycles with M_AXIS_tvalid=0, then 1 IDLE cycle before the second frame's first beat.
REQ-034 Src_Enable=4'b1101 with all sources valid -> source 1 is never granted; Src_Enable cleared mid-frame on the granted source -> frame still completes.
REQ-035 ARESET pulsed on beat 2 of a 5-beat frame -> all outputs at reset values within the same cycle; Frames_Sent=0; next grant is source 0 if valid.
REQ-036 Frames_Sent preloaded by 65535 frames of 1 beat -> next frame wraps Frames_Sent to 0.
